// File: rtl/halli_galli_arbiter.sv
// Halli Galli referee: deals cards into per-player face-up slots, judges bell
// presses against the same-colour target sum and keeps per-player scores.
module halli_galli_arbiter #(
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 8,
   parameter int TARGET      = 5,
   parameter int MAX_CARDS   = 40,
   parameter int LOCK_CYC    = 4,
   parameter int FINAL_WIN   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           card_valid,
   input  logic [1:0]                     card_color,
   input  logic [2:0]                     card_number,
   input  logic [NUM_PLAYERS-1:0]         bell,
   output logic [$clog2(NUM_PLAYERS)-1:0] turn,
   output logic [NUM_PLAYERS*SCORE_W-1:0] score,
   output logic                           ring_ok,
   output logic                           ring_bad,
   output logic [$clog2(NUM_PLAYERS)-1:0] ring_who,
   output logic                           card_dropped,
   output logic                           game_over,
   output logic [$clog2(NUM_PLAYERS)-1:0] winner,
   output logic                           winner_tie
);

   localparam int PW   = $clog2(NUM_PLAYERS);
   localparam int CW   = $clog2(MAX_CARDS + 1);
   localparam int TMAX = (FINAL_WIN > LOCK_CYC) ? FINAL_WIN : LOCK_CYC;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      PLAY,
      FINAL,
      JUDGE,
      LOCK,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [NUM_PLAYERS-1:0] slot_valid;
   logic [1:0]             slot_color [NUM_PLAYERS];
   logic [2:0]             slot_num   [NUM_PLAYERS];
   logic [SCORE_W-1:0]     score_q    [NUM_PLAYERS];
   logic [CW-1:0]          card_count;
   logic [TW-1:0]          timer;
   logic                   match_q;

   logic [4:0]             color_sum  [4];
   logic                   match;
   logic                   bell_any;
   logic [PW-1:0]          bell_idx;
   logic [SCORE_W-1:0]     lead_max;
   logic [PW-1:0]          lead_idx;
   logic                   lead_tie;
   logic                   last_deal;

   // Same-colour sums over valid slots; 4 slots x 7 fits in 5 bits, so no wrap.
   always_comb begin
      match = 1'b0;
      for (int unsigned c = 0; c < 4; c++) begin
         color_sum[c] = '0;
         for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (slot_valid[p] && slot_color[p] == 2'(c))
               color_sum[c] = color_sum[c] + {2'b00, slot_num[p]};
         end
         if (color_sum[c] == 5'(TARGET))
            match = 1'b1;
      end
   end

   // Lowest-index bell wins a simultaneous press.
   always_comb begin
      bell_any = |bell;
      bell_idx = '0;
      for (int unsigned i = NUM_PLAYERS; i > 0; i--) begin
         if (bell[i-1])
            bell_idx = PW'(i - 1);
      end
   end

   always_comb begin
      lead_max = score_q[0];
      lead_idx = '0;
      lead_tie = 1'b0;
      for (int unsigned i = 1; i < NUM_PLAYERS; i++) begin
         if (score_q[i] > lead_max) begin
            lead_max = score_q[i];
            lead_idx = PW'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         if (score_q[i] == lead_max && PW'(i) != lead_idx)
            lead_tie = 1'b1;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++)
         score[i*SCORE_W +: SCORE_W] = score_q[i];
   end

   assign last_deal = card_valid && (card_count == CW'(MAX_CARDS - 1));

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= PLAY;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PLAY: begin
            if (bell_any)
               state_d = JUDGE;
            else if (last_deal)
               state_d = FINAL;
         end
         FINAL: begin
            if (bell_any)
               state_d = JUDGE;
            else if (timer == '0)
               state_d = DONE;
         end
         JUDGE:   state_d = LOCK;
         LOCK: begin
            if (timer == '0)
               state_d = (card_count == CW'(MAX_CARDS)) ? DONE : PLAY;
         end
         DONE:    state_d = DONE;
         default: state_d = PLAY;
      endcase
   end

   always_comb begin
      ring_ok   = (state_q == JUDGE) &&  match_q;
      ring_bad  = (state_q == JUDGE) && !match_q;
      game_over = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         turn         <= '0;
         card_count   <= '0;
         timer        <= '0;
         match_q      <= 1'b0;
         ring_who     <= '0;
         card_dropped <= 1'b0;
         winner       <= '0;
         winner_tie   <= 1'b0;
         slot_valid   <= '0;
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            slot_color[i] <= '0;
            slot_num[i]   <= '0;
            score_q[i]    <= '0;
         end
      end else begin
         // Only an uncontested deal in PLAY is accepted; every other deal is dropped.
         card_dropped <= card_valid && !(state_q == PLAY && !bell_any);

         case (state_q)
            PLAY: begin
               if (bell_any) begin
                  ring_who <= bell_idx;
                  match_q  <= match;
               end else if (card_valid) begin
                  slot_valid[turn] <= 1'b1;
                  slot_color[turn] <= card_color;
                  slot_num[turn]   <= card_number;
                  turn             <= (turn == PW'(NUM_PLAYERS - 1)) ? '0 : turn + PW'(1);
                  card_count       <= card_count + CW'(1);
                  if (last_deal)
                     timer <= TW'(FINAL_WIN - 1);
               end
            end
            FINAL: begin
               if (bell_any) begin
                  ring_who <= bell_idx;
                  match_q  <= match;
               end else if (timer != '0) begin
                  timer <= timer - TW'(1);
               end
            end
            JUDGE: begin
               if (match_q) begin
                  if (score_q[ring_who] != '1)
                     score_q[ring_who] <= score_q[ring_who] + SCORE_W'(1);
                  slot_valid <= '0;
               end else if (score_q[ring_who] != '0) begin
                  score_q[ring_who] <= score_q[ring_who] - SCORE_W'(1);
               end
               timer <= TW'(LOCK_CYC - 1);
            end
            LOCK: begin
               if (timer != '0)
                  timer <= timer - TW'(1);
            end
            default: ;
         endcase

         // Scores are final on the edge that enters DONE, so rank them here.
         if (state_d == DONE && state_q != DONE) begin
            winner     <= lead_idx;
            winner_tie <= lead_tie;
         end
      end
   end

endmodule

// File: tb/tb_halli_galli_arbiter.sv
// Directed bench for halli_galli_arbiter with default parameters: a vector
// table for the dealing/judging flow plus hand-written end-of-game sequences.
module tb_halli_galli_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        card_valid;
   logic [1:0]  card_color;
   logic [2:0]  card_number;
   logic [1:0]  bell;
   logic [0:0]  turn;
   logic [15:0] score;
   logic        ring_ok;
   logic        ring_bad;
   logic [0:0]  ring_who;
   logic        card_dropped;
   logic        game_over;
   logic [0:0]  winner;
   logic        winner_tie;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   halli_galli_arbiter #(
      .NUM_PLAYERS(2),
      .SCORE_W    (8),
      .TARGET     (5),
      .MAX_CARDS  (40),
      .LOCK_CYC   (4),
      .FINAL_WIN  (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .card_valid  (card_valid),
      .card_color  (card_color),
      .card_number (card_number),
      .bell        (bell),
      .turn        (turn),
      .score       (score),
      .ring_ok     (ring_ok),
      .ring_bad    (ring_bad),
      .ring_who    (ring_who),
      .card_dropped(card_dropped),
      .game_over   (game_over),
      .winner      (winner),
      .winner_tie  (winner_tie)
   );

   typedef struct {
      logic        cv;
      logic [1:0]  col;
      logic [2:0]  num;
      logic [1:0]  b;
      logic [0:0]  e_turn;
      logic        e_ok;
      logic        e_bad;
      logic [0:0]  e_who;
      logic [15:0] e_score;
      logic        e_drop;
      logic        e_over;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Inputs are applied for one cycle; outputs are sampled 1 time unit after the edge.
   task automatic tick(input logic cv, input logic [1:0] col, input logic [2:0] num,
                       input logic [1:0] b);
      card_valid  = cv;
      card_color  = col;
      card_number = num;
      bell        = b;
      @(posedge clk);
      #1;
      card_valid = 1'b0;
      bell       = 2'b00;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++)
         tick(1'b0, 2'd0, 3'd0, 2'b00);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 2'd0, 3'd0, 2'b00);
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " turn"},    turn,         0);
      check({tag, " score"},   score,        0);
      check({tag, " ok"},      ring_ok,      0);
      check({tag, " bad"},     ring_bad,     0);
      check({tag, " who"},     ring_who,     0);
      check({tag, " drop"},    card_dropped, 0);
      check({tag, " over"},    game_over,    0);
      check({tag, " winner"},  winner,       0);
      check({tag, " tie"},     winner_tie,   0);
   endtask

   initial begin
      rst         = 1'b1;
      card_valid  = 1'b0;
      card_color  = 2'd0;
      card_number = 3'd0;
      bell        = 2'b00;
      idle(2);
      rst = 1'b0;
      check_all_zero("reset");

      //                cv    col   num   bell   turn  ok    bad   who   score     drop  over
      vecs.push_back('{1'b1, 2'd1, 3'd2, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'd1, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'd0, 3'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'd0, 3'd2, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'd1, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
      for (int unsigned i = 0; i < 4; i++)
         vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'd1, 3'd2, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'd0, 3'd1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0});
      for (int unsigned i = 0; i < 4; i++)
         vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'd1, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0101, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         tick(vecs[i].cv, vecs[i].col, vecs[i].num, vecs[i].b);
         check($sformatf("v%0d turn", i),  turn,         vecs[i].e_turn);
         check($sformatf("v%0d ok", i),    ring_ok,      vecs[i].e_ok);
         check($sformatf("v%0d bad", i),   ring_bad,     vecs[i].e_bad);
         check($sformatf("v%0d who", i),   ring_who,     vecs[i].e_who);
         check($sformatf("v%0d score", i), score,        vecs[i].e_score);
         check($sformatf("v%0d drop", i),  card_dropped, vecs[i].e_drop);
         check($sformatf("v%0d over", i),  game_over,    vecs[i].e_over);
      end

      // Full deck, no bell, final window runs out: 0/0 scores tie on player 0.
      do_reset();
      for (int unsigned i = 0; i < 40; i++)
         tick(1'b1, 2'(i % 4), 3'(i % 8), 2'b00);
      check("deck turn", turn, 0);
      check("deck over", game_over, 0);
      tick(1'b1, 2'd1, 3'd1, 2'b00);
      check("final drop", card_dropped, 1);
      check("final turn", turn, 0);
      idle(14);
      check("final win-1 over", game_over, 0);
      idle(1);
      check("final expire over", game_over, 1);
      check("final winner", winner, 0);
      check("final tie", winner_tie, 1);
      tick(1'b1, 2'd1, 3'd2, 2'b01);
      check("done drop", card_dropped, 1);
      check("done bad", ring_bad, 0);
      check("done ok", ring_ok, 0);
      check("done over", game_over, 1);
      check("done score", score, 0);

      // Player 1 scores, then a wrong bell in FINAL leads through LOCK to DONE.
      do_reset();
      tick(1'b1, 2'd2, 3'd5, 2'b00);
      tick(1'b0, 2'd0, 3'd0, 2'b10);
      check("p1 ok", ring_ok, 1);
      idle(5);
      check("p1 score", score, 16'h0100);
      for (int unsigned i = 0; i < 39; i++)
         tick(1'b1, 2'd3, 3'd0, 2'b00);
      tick(1'b0, 2'd0, 3'd0, 2'b01);
      check("fbell bad", ring_bad, 1);
      check("fbell who", ring_who, 0);
      idle(1);
      check("fbell score", score, 16'h0100);
      idle(3);
      check("fbell lock over", game_over, 0);
      idle(1);
      check("fbell done over", game_over, 1);
      check("fbell winner", winner, 1);
      check("fbell tie", winner_tie, 0);

      // Reset in the cycle after JUDGE clears everything, then play resumes.
      do_reset();
      tick(1'b1, 2'd1, 3'd5, 2'b00);
      tick(1'b0, 2'd0, 3'd0, 2'b10);
      check("rstL ok", ring_ok, 1);
      idle(1);
      check("rstL score", score, 16'h0100);
      rst = 1'b1;
      tick(1'b1, 2'd0, 3'd1, 2'b00);
      rst = 1'b0;
      check_all_zero("rstL");
      tick(1'b1, 2'd0, 3'd1, 2'b00);
      check("rstL play turn", turn, 1);
      check("rstL play drop", card_dropped, 0);

      // Reset during JUDGE overrides the judgement.
      do_reset();
      tick(1'b1, 2'd1, 3'd5, 2'b00);
      tick(1'b0, 2'd0, 3'd0, 2'b01);
      check("rstJ ok", ring_ok, 1);
      rst = 1'b1;
      tick(1'b0, 2'd0, 3'd0, 2'b00);
      rst = 1'b0;
      check_all_zero("rstJ");
      tick(1'b1, 2'd0, 3'd1, 2'b00);
      check("rstJ play turn", turn, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
